// File: rtl/ddr4_dq_rx_bitslip_train.sv
// ============================================================================
// Module   : ddr4_dq_rx_bitslip_train
// Purpose  : DQ lane RX word alignment: slips the IOD deserialiser until the
//            captured word matches the training pattern, then forwards reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr4_dq_rx_bitslip_train #(
  parameter logic [7:0]  TRAIN_PATTERN = 8'h1D,
  parameter int unsigned MATCH_COUNT   = 4,
  parameter int unsigned SLIP_WAIT     = 3,
  parameter int unsigned MAX_SLIPS     = 7
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       TRAIN_START,
  input  logic [7:0] RX_DATA_0,
  input  logic       RX_VALID_IN,
  output logic       RX_BIT_SLIP_0,
  output logic       TRAIN_BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_FAIL,
  output logic [3:0] SLIP_COUNT,
  output logic [7:0] RD_DATA,
  output logic       RD_VALID
);

  localparam logic [3:0] c_match_last = 4'(MATCH_COUNT - 1);
  localparam logic [3:0] c_slip_wait  = 4'(SLIP_WAIT);
  localparam logic [3:0] c_max_slips  = 4'(MAX_SLIPS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_SLIP   = 3'd2,
    S_WAIT   = 3'd3,
    S_LOCKED = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       w_start_check;
  logic       w_match;
  logic [3:0] r_match_cnt;
  logic [3:0] r_wait_cnt;
  logic [3:0] r_slip_count;
  logic       r_slip;
  logic [7:0] r_rd_data;
  logic       r_rd_valid;

  assign w_match = RX_VALID_IN && (RX_DATA_0 == TRAIN_PATTERN);

  always_comb begin
    w_next_state  = r_state;
    w_start_check = 1'b0;
    case (r_state)
      S_IDLE, S_LOCKED, S_FAIL: begin
        if (TRAIN_START) begin
          w_next_state  = S_CHECK;
          w_start_check = 1'b1;
        end
      end
      S_CHECK: begin
        if (RX_VALID_IN) begin
          if (w_match) begin
            if (r_match_cnt == c_match_last) w_next_state = S_LOCKED;
          end else if (r_slip_count < c_max_slips) begin
            w_next_state = S_SLIP;
          end else begin
            w_next_state = S_FAIL;
          end
        end
      end
      // wait_cnt is loaded on entry to SLIP, so the slip cycle itself counts
      // as the first settle cycle; pulse spacing is SLIP_WAIT+1.
      S_SLIP:  w_next_state = (r_wait_cnt <= 4'd1) ? S_CHECK : S_WAIT;
      S_WAIT:  if (r_wait_cnt <= 4'd1) w_next_state = S_CHECK;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_state      <= S_IDLE;
      r_match_cnt  <= 4'd0;
      r_wait_cnt   <= 4'd0;
      r_slip_count <= 4'd0;
      r_slip       <= 1'b0;
      r_rd_data    <= 8'h00;
      r_rd_valid   <= 1'b0;
    end else begin
      r_state <= w_next_state;

      // Only meaningful in CHECK; every entry to CHECK therefore starts at 0.
      if (r_state != S_CHECK)  r_match_cnt <= 4'd0;
      else if (RX_VALID_IN)    r_match_cnt <= w_match ? r_match_cnt + 4'd1 : 4'd0;

      if (w_next_state == S_SLIP)                          r_wait_cnt <= c_slip_wait;
      else if ((r_state == S_SLIP || r_state == S_WAIT) &&
               (r_wait_cnt != 4'd0))                       r_wait_cnt <= r_wait_cnt - 4'd1;

      if (w_start_check)
        r_slip_count <= 4'd0;
      else if (w_next_state == S_SLIP && r_slip_count < c_max_slips)
        r_slip_count <= r_slip_count + 4'd1;

      r_slip <= (w_next_state == S_SLIP);

      if (RX_VALID_IN) r_rd_data <= RX_DATA_0;
      // Gated on the next state so RD_VALID falls in the same cycle LOCKED is left.
      r_rd_valid <= RX_VALID_IN && (w_next_state == S_LOCKED);
    end
  end

  assign RX_BIT_SLIP_0 = r_slip;
  assign TRAIN_BUSY    = (r_state == S_CHECK) || (r_state == S_SLIP) || (r_state == S_WAIT);
  assign TRAIN_DONE    = (r_state == S_LOCKED);
  assign TRAIN_FAIL    = (r_state == S_FAIL);
  assign SLIP_COUNT    = r_slip_count;
  assign RD_DATA       = r_rd_data;
  assign RD_VALID      = r_rd_valid;

endmodule

`default_nettype wire
